// File: rtl/mc_pkg.sv
// Shared encodings for the mc_ctrl multi-cycle sequencer: states, opcodes,
// func codes, ALU codes, next-PC selects and the decoded-instruction payload.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_LUI  = 3'b101;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JMP  = 2'd2;

  typedef enum logic [2:0] {
    C_R, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_ILL
  } iclass_e;

  typedef struct packed {
    iclass_e    cls;
    logic [2:0] alu_op;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational decode of the latched opcode/func into instruction class,
// ALU function and a legal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output dec_t       dec
);

  always_comb begin
    dec.cls    = C_ILL;
    dec.alu_op = ALU_ADD;
    dec.legal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: begin dec.cls = C_R; dec.alu_op = ALU_ADD; end
          FN_SUBU: begin dec.cls = C_R; dec.alu_op = ALU_SUB; end
          FN_AND:  begin dec.cls = C_R; dec.alu_op = ALU_AND; end
          FN_OR:   begin dec.cls = C_R; dec.alu_op = ALU_OR;  end
          FN_SLT:  begin dec.cls = C_R; dec.alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ORI:  begin dec.cls = C_ORI; dec.alu_op = ALU_OR;  end
      OP_LUI:  begin dec.cls = C_LUI; dec.alu_op = ALU_LUI; end
      OP_LW:   begin dec.cls = C_LW;  dec.alu_op = ALU_ADD; end
      OP_SW:   begin dec.cls = C_SW;  dec.alu_op = ALU_ADD; end
      OP_BEQ:  begin dec.cls = C_BEQ; dec.alu_op = ALU_SUB; end
      OP_J:    begin dec.cls = C_J;   dec.alu_op = ALU_ADD; end
      default: ;
    endcase
    dec.legal = (dec.cls != C_ILL);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the MIPS-lite datapath.
// Define MC_CTRL_PERF_EN to build the cycle/retired-instruction counters.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       npc_sel,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             ext_op,
  output logic [2:0]       alu_op,
  output logic             mem_wr,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam int unsigned WCMP_W = WAIT_W + 1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W:0]   wait_nxt;
  logic              timeout;
  dec_t              dec;

  mc_decode u_decode (
    .opcode (opcode),
    .func   (func),
    .dec    (dec)
  );

  // Timeout fires on the not-ready cycle that would bring the count to WAIT_MAX;
  // ready in that same cycle takes priority.
  assign wait_nxt = {1'b0, wait_q} + WCMP_W'(1);
  assign timeout  = (WAIT_MAX != 0) && (wait_nxt == WCMP_W'(WAIT_MAX));
  assign state    = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    npc_sel    = NPC_SEQ;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    alu_op     = ALU_ADD;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;

    // ALU controls are set in EX and held through MEM and WB
    if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
      alu_op  = dec.alu_op;
      alu_src = dec.cls inside {C_ORI, C_LUI, C_LW, C_SW};
      ext_op  = dec.cls inside {C_LW, C_SW};
    end

    case (state_q)
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          npc_sel = NPC_SEQ;
          state_d = S_ID;
        end else begin
          wait_d = wait_nxt[WAIT_W-1:0];
          if (timeout) state_d = S_TRAP;
        end
      end
      S_ID: state_d = dec.legal ? S_EX : S_TRAP;
      S_EX: begin
        case (dec.cls)
          C_R, C_ORI, C_LUI: state_d = S_WB;
          C_LW, C_SW:        state_d = S_MEM;
          C_BEQ: begin
            pc_wr   = zero;
            npc_sel = NPC_BR;
            state_d = S_IF;
          end
          C_J: begin
            pc_wr   = 1'b1;
            npc_sel = NPC_JMP;
            state_d = S_IF;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        mem_wr   = (dec.cls == C_SW);
        if (dmem_ready) begin
          state_d = (dec.cls == C_SW) ? S_IF : S_WB;
        end else begin
          wait_d = wait_nxt[WAIT_W-1:0];
          if (timeout) state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = (dec.cls != C_R);
        mem_to_reg = (dec.cls == C_LW);
        state_d    = S_IF;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_IF;
    endcase

    // Reset aborts combinationally so no write lands after rst rises
    if (rst) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      ir_wr      = 1'b0;
      pc_wr      = 1'b0;
      reg_wr     = 1'b0;
      mem_wr     = 1'b0;
      mem_to_reg = 1'b0;
      trap       = 1'b0;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_q, cycle_d, instr_q, instr_d;
  logic             retire;

  assign retire = (state_q == S_EX  && dec.cls inside {C_BEQ, C_J}) ||
                  (state_q == S_MEM && dec.cls == C_SW && dmem_ready) ||
                  (state_q == S_WB);

  always_comb begin
    cycle_d = cycle_q + CNT_W'(1);
    instr_d = instr_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle sequencing controller for the MIPS-lite datapath (PC, NPC, instruction memory, regfile, sign-extend, ALU, data memory).
- Replaces single-cycle decode: FSM walks each instruction through IF/ID/EX/MEM/WB, issuing per-state write enables, mux selects and memory requests.
- Stalls on memory ready handshakes; traps on illegal opcode.

Parameters:
- WAIT_MAX, 15, cycles a memory request may wait for ready before trapping; 0 disables the timeout.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26] from latched IR
- func  in  6  instr[5:0] from latched IR
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  fetch request
- dmem_req  out  1  data access request
- ir_wr  out  1  latch instruction register
- pc_wr  out  1  PC update enable
- npc_sel  out  2  0=PC+4, 1=branch target, 2=jump target
- reg_wr  out  1  regfile write enable
- reg_dst  out  1  1 selects rt, 0 selects rd
- alu_src  out  1  1 selects extended immediate
- ext_op  out  1  1 sign-extend, 0 zero-extend
- alu_op  out  3  ALU function code
- mem_wr  out  1  data memory write
- mem_to_reg  out  1  1 selects memory read data for writeback
- trap  out  1  sticky illegal-instruction/timeout flag
- state  out  3  current FSM state, debug
- cycle_cnt  out  CNT_W  cycles since reset
- instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (async, rst=1):
  - state=S_IF; trap=0; counters=0; wait counter=0.
  - All enables 0 while rst asserted.
- States:
  - S_IF=0: imem_req=1. When imem_ready=1: ir_wr=1, pc_wr=1, npc_sel=0, go to S_ID. Otherwise stay.
  - S_ID=1: decode the latched opcode/func.
    - Legal: go to S_EX.
    - Illegal: go to S_TRAP.
  - S_EX=2:
    - R-type: alu_src=0, alu_op from func. Go to S_WB.
    - ori: alu_src=1, ext_op=0, alu_op=OR. Go to S_WB.
    - lui: alu_op=LUI. Go to S_WB.
    - lw/sw: alu_src=1, ext_op=1, alu_op=ADD. Go to S_MEM.
    - beq: alu_op=SUB. pc_wr=zero, npc_sel=1. Retire, go to S_IF.
    - j: pc_wr=1, npc_sel=2. Retire, go to S_IF.
  - S_MEM=3: dmem_req=1; mem_wr=1 for sw only. Hold until dmem_ready=1.
    - sw: retire, go to S_IF.
    - lw: go to S_WB.
  - S_WB=4: reg_wr=1; reg_dst=1 for ori/lui/lw, 0 for R-type; mem_to_reg=1 for lw only. Retire, go to S_IF.
  - S_TRAP=5: trap=1; all enables 0. Stays until rst.
- Outputs are combinational from state and the latched opcode/func. ALU-controlling outputs hold their EX values through MEM and WB.
- Latency in cycles with zero wait states:
  - R/ori/lui: 4
  - lw: 5
  - sw: 4
  - beq/j: 3
  - Each cycle with ready=0 adds one cycle.
- Timeout: wait counter increments each cycle in S_IF/S_MEM while ready=0 and clears on ready. If WAIT_MAX>0 and the count reaches WAIT_MAX, go to S_TRAP.
- Ready arriving in the same cycle the timeout is reached: ready wins, no trap.
- Write enables (reg_wr, mem_wr, pc_wr) never assert in S_ID or S_TRAP.
- Legal R-type func codes: addu 100001, subu 100011, and 100100, or 100101, slt 101010. Any other func code is illegal.
- Reset mid-instruction aborts immediately; no write completes after rst rises.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- Defined:
  - cycle_cnt increments every non-reset cycle; wraps at 2^CNT_W.
  - instr_cnt increments on each retire; does not increment in S_TRAP.
- Undefined: both counter ports driven constant 0 and no counter flops are inferred. Ports exist in both builds.

Decomposition:
- Package mc_pkg:
  - State encodings S_IF..S_TRAP.
  - Opcode constants: RTYPE 000000, ORI 001101, LUI 001111, LW 100011, SW 101011, BEQ 000100, J 000010.
  - Func constants (listed above).
  - ALU codes: ADD 000, SUB 001, AND 010, OR 011, SLT 100, LUI 101.
  - npc_sel codes.
- One sub-module mc_decode: combinational opcode/func to instruction class, alu_op and legal flag. The FSM stays in mc_ctrl.

Test Plan:
- addu, ready tied 1 -> states IF,ID,EX,WB; reg_wr=1, reg_dst=0 in cycle 4 only; instr_cnt=1.
- lw with dmem_ready low 3 cycles -> S_MEM held 4 cycles; total 8 cycles; mem_to_reg=1, reg_wr=1 in WB; mem_wr never asserted.
- beq with zero=1 then zero=0 -> first: pc_wr=1, npc_sel=1 in EX; second: pc_wr=0 in EX; both 3 cycles.
- opcode 111111 -> S_TRAP after ID; trap=1; no enables for 20 cycles; instr_cnt unchanged.
- imem_ready held 0, WAIT_MAX=15 -> trap asserted after 15 wait cycles; imem_ready=1 exactly at the limit -> no trap.
- rst pulsed during S_MEM of sw -> mem_wr drops same cycle; state=S_IF, counters 0 after release.
